// File: rtl/data_dispatch.sv
// rtl/data_dispatch.sv - tagged-word dispatcher into three slot-rate-drained channel FIFOs
// Purpose: routes each valid input word into FIFO a/b/c selected by `channel`.
//   FIFO a pops every 2nd cycle, b every 4th and c every 8th, all aligned to a shared
//   free-running slot counter. Channel 3 words are dropped without stalling upstream.
// Optional feature macro: DISPATCH_ERR_CNT_EN (saturating count of dropped channel-3 words).
// Ports:
//   clkd, rst                   - clock, synchronous active-high reset
//   din, din_vld, channel       - input word, valid, target channel (0=a, 1=b, 2=c, 3=drop)
//   din_rdy                     - combinational accept for the currently addressed channel
//   data_a/b/c, data_a/b/c_vld  - channel outputs, valid held for one whole slot
//   err_cnt                     - dropped channel-3 word count (0 when feature disabled)
module data_dispatch #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clkd,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic [1:0]    channel,
  output logic          din_rdy,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic [DW-1:0] data_c,
  output logic          data_a_vld,
  output logic          data_b_vld,
  output logic          data_c_vld,
  output logic [7:0]    err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0] slot_cnt;
  logic [2:0] tick;
  logic [2:0] full;
  logic [3:0] full_ext;

  assign tick[0] = slot_cnt[0];
  assign tick[1] = &slot_cnt[1:0];
  assign tick[2] = &slot_cnt;

  // Channel 3 maps onto a constant 0 entry so it always reads as ready.
  assign full_ext = {1'b0, full};
  assign din_rdy  = rst | ~full_ext[channel];

  always_ff @(posedge clkd) begin
    if (rst) begin
      slot_cnt <= 3'd0;
    end else begin
      slot_cnt <= slot_cnt + 3'd1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] data_q;
    logic          vld_q;
    logic          empty;
    logic          full_q;
    logic          wr_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full_q  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign full[g] = full_q;
    // No write-through when full, even if a pop lands on the same edge.
    assign wr_en   = din_vld && !rst && !full_q && (channel == 2'(g));

    always_ff @(posedge clkd) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr[AW-1:0]] <= din;
          wr_ptr              <= wr_ptr + (AW+1)'(1);
        end
        // Pop decision uses pre-edge emptiness, so a same-edge write is never bypassed.
        if (tick[g]) begin
          if (!empty) begin
            data_q <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + (AW+1)'(1);
            vld_q  <= 1'b1;
          end else begin
            vld_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign data_a     = g_ch[0].data_q;
  assign data_b     = g_ch[1].data_q;
  assign data_c     = g_ch[2].data_q;
  assign data_a_vld = g_ch[0].vld_q;
  assign data_b_vld = g_ch[1].vld_q;
  assign data_c_vld = g_ch[2].vld_q;

`ifdef DISPATCH_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clkd) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (din_vld && (channel == 2'd3) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_data_dispatch.sv
// tb/tb_data_dispatch.sv - directed self-checking bench for data_dispatch
module tb_data_dispatch;

  logic        clkd = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_vld;
  logic [1:0]  channel;
  logic        din_rdy;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] data_c;
  logic        data_a_vld;
  logic        data_b_vld;
  logic        data_c_vld;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

`ifdef DISPATCH_ERR_CNT_EN
  localparam logic [7:0] ERR_AFTER_3 = 8'd3;
`else
  localparam logic [7:0] ERR_AFTER_3 = 8'd0;
`endif

  data_dispatch #(.DW(16), .DEPTH(4)) dut (
    .clkd       (clkd),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .channel    (channel),
    .din_rdy    (din_rdy),
    .data_a     (data_a),
    .data_b     (data_b),
    .data_c     (data_c),
    .data_a_vld (data_a_vld),
    .data_b_vld (data_b_vld),
    .data_c_vld (data_c_vld),
    .err_cnt    (err_cnt)
  );

  always #5 clkd = ~clkd;

  // Holds reset for n edges; returns 1 time unit after the last reset edge with rst low,
  // so the next rising edge is cycle 0 (slot_cnt 0 -> 1).
  task automatic apply_reset(input int n);
    rst     = 1'b1;
    din_vld = 1'b0;
    channel = 2'd0;
    din     = 16'h0;
    repeat (n) @(posedge clkd);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    din_vld = 1'b1;
    channel = 2'd0;
    din     = 16'hDEAD;
    repeat (3) @(posedge clkd);
    @(negedge clkd);
    checks++;
    if ({data_a_vld, data_b_vld, data_c_vld} !== 3'b000) begin
      errors++;
      $display("FAIL reset_vld got=%b exp=000", {data_a_vld, data_b_vld, data_c_vld});
    end
    checks++;
    if ({data_a, data_b, data_c} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {data_a, data_b, data_c});
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt);
    end
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_rdy got=%b exp=1", din_rdy);
    end
    rst     = 1'b0;
    din_vld = 1'b0;
    // Nothing may have been written during reset: ticks at cycles 1 and 3 find FIFO a empty.
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clkd);
      @(negedge clkd);
      checks++;
      if (data_a_vld !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_write cyc=%0d got=%b exp=0", cyc, data_a_vld);
      end
    end
  endtask

  task automatic test_single_words();
    logic        exp_av, exp_bv, exp_cv;
    logic [15:0] exp_a, exp_b, exp_c;
    apply_reset(2);
    for (int cyc = 0; cyc < 17; cyc++) begin
      din_vld = (cyc < 3);
      channel = 2'(cyc);
      din     = (cyc == 0) ? 16'h0011 : (cyc == 1) ? 16'h0022 : 16'h0033;
      @(posedge clkd);
      @(negedge clkd);
      exp_av = (cyc == 1) || (cyc == 2);
      exp_bv = (cyc >= 3) && (cyc <= 6);
      exp_cv = (cyc >= 7) && (cyc <= 14);
      exp_a  = (cyc >= 1) ? 16'h0011 : 16'h0;
      exp_b  = (cyc >= 3) ? 16'h0022 : 16'h0;
      exp_c  = (cyc >= 7) ? 16'h0033 : 16'h0;
      checks++;
      if ({data_a_vld, data_b_vld, data_c_vld} !== {exp_av, exp_bv, exp_cv}) begin
        errors++;
        $display("FAIL single_vld cyc=%0d got=%b exp=%b", cyc,
                 {data_a_vld, data_b_vld, data_c_vld}, {exp_av, exp_bv, exp_cv});
      end
      checks++;
      if ({data_a, data_b, data_c} !== {exp_a, exp_b, exp_c}) begin
        errors++;
        $display("FAIL single_data cyc=%0d got=%h exp=%h", cyc,
                 {data_a, data_b, data_c}, {exp_a, exp_b, exp_c});
      end
    end
  endtask

  task automatic test_backpressure();
    int   w;
    int   acc_cyc [7];
    logic acc;
    w = 1;
    for (int i = 0; i < 7; i++) acc_cyc[i] = -1;
    apply_reset(2);
    channel = 2'd2;
    din     = 16'd1;
    din_vld = 1'b1;
    for (int cyc = 0; cyc < 57; cyc++) begin
      @(negedge clkd);
      if (cyc == 4) begin
        checks++;
        if (din_rdy !== 1'b0) begin
          errors++;
          $display("FAIL bp_rdy_full got=%b exp=0", din_rdy);
        end
      end
      acc = din_vld && din_rdy;
      @(posedge clkd);
      if (acc) begin
        acc_cyc[w] = cyc;
        w++;
      end
      #1;
      if (cyc % 8 == 7) begin
        checks++;
        if (data_c_vld !== (cyc <= 47)) begin
          errors++;
          $display("FAIL bp_vld cyc=%0d got=%b exp=%b", cyc, data_c_vld, (cyc <= 47));
        end
        checks++;
        if (data_c !== ((cyc <= 47) ? 16'((cyc + 1) / 8) : 16'd6)) begin
          errors++;
          $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, data_c,
                   (cyc <= 47) ? 16'((cyc + 1) / 8) : 16'd6);
        end
      end
      din     = 16'(w);
      din_vld = (w <= 6);
    end
    din_vld = 1'b0;
    checks++;
    if (acc_cyc[4] !== 3) begin
      errors++;
      $display("FAIL bp_acc4 got=%0d exp=3", acc_cyc[4]);
    end
    checks++;
    if (acc_cyc[5] !== 8) begin
      errors++;
      $display("FAIL bp_acc5 got=%0d exp=8", acc_cyc[5]);
    end
    checks++;
    if (acc_cyc[6] !== 16) begin
      errors++;
      $display("FAIL bp_acc6 got=%0d exp=16", acc_cyc[6]);
    end
  endtask

  task automatic test_collision();
    int nwr;
    nwr = 0;
    apply_reset(2);
    channel = 2'd0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      din_vld = (cyc == 0) || ((cyc % 2 == 1) && (cyc <= 13));
      din     = 16'h0100 + 16'(nwr);
      @(negedge clkd);
      checks++;
      if (din_rdy !== 1'b1) begin
        errors++;
        $display("FAIL coll_rdy cyc=%0d got=%b exp=1", cyc, din_rdy);
      end
      @(posedge clkd);
      if (din_vld) nwr++;
      #1;
      if (cyc % 2 == 1) begin
        checks++;
        if (data_a_vld !== (cyc <= 15)) begin
          errors++;
          $display("FAIL coll_vld cyc=%0d got=%b exp=%b", cyc, data_a_vld, (cyc <= 15));
        end
        checks++;
        if (data_a !== ((cyc <= 15) ? 16'h0100 + 16'((cyc - 1) / 2) : 16'h0107)) begin
          errors++;
          $display("FAIL coll_data cyc=%0d got=%h exp=%h", cyc, data_a,
                   (cyc <= 15) ? 16'h0100 + 16'((cyc - 1) / 2) : 16'h0107);
        end
      end
    end
    din_vld = 1'b0;
  endtask

  task automatic test_invalid();
    apply_reset(2);
    channel = 2'd3;
    for (int cyc = 0; cyc < 12; cyc++) begin
      din_vld = (cyc < 3);
      din     = 16'hE000 + 16'(cyc);
      @(negedge clkd);
      if (cyc < 3) begin
        checks++;
        if (din_rdy !== 1'b1) begin
          errors++;
          $display("FAIL inv_rdy cyc=%0d got=%b exp=1", cyc, din_rdy);
        end
      end
      @(posedge clkd);
      #1;
      checks++;
      if ({data_a_vld, data_b_vld, data_c_vld, data_a, data_b, data_c} !== 51'h0) begin
        errors++;
        $display("FAIL inv_outputs cyc=%0d got=%h exp=0", cyc,
                 {data_a_vld, data_b_vld, data_c_vld, data_a, data_b, data_c});
      end
    end
    checks++;
    if (err_cnt !== ERR_AFTER_3) begin
      errors++;
      $display("FAIL inv_err_cnt got=%0d exp=%0d", err_cnt, ERR_AFTER_3);
    end
`ifdef DISPATCH_ERR_CNT_EN
    din_vld = 1'b1;
    repeat (300) @(posedge clkd);
    #1;
    din_vld = 1'b0;
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL inv_err_sat got=%0d exp=255", err_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    apply_reset(2);
    channel = 2'd1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      din_vld = (cyc < 3);
      din     = 16'h0B01 + 16'(cyc);
      @(posedge clkd);
      #1;
    end
    checks++;
    if ({data_b_vld, data_b} !== {1'b1, 16'h0B01}) begin
      errors++;
      $display("FAIL mid_first_pop got=%h exp=%h", {data_b_vld, data_b}, {1'b1, 16'h0B01});
    end
    rst     = 1'b1;
    din_vld = 1'b0;
    @(negedge clkd);
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rdy_in_reset got=%b exp=1", din_rdy);
    end
    @(posedge clkd);
    #1;
    checks++;
    if ({data_b_vld, data_b} !== 17'h0) begin
      errors++;
      $display("FAIL mid_reset_out got=%h exp=0", {data_b_vld, data_b});
    end
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clkd);
      #1;
      checks++;
      if (data_b_vld !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale cyc=%0d got=%b exp=0", cyc, data_b_vld);
      end
    end
    din_vld = 1'b1;
    channel = 2'd1;
    din     = 16'hBEEF;
    @(posedge clkd);
    #1;
    din_vld = 1'b0;
    @(posedge clkd);
    #1;
    checks++;
    if ({data_b_vld, data_b} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL mid_new_word got=%h exp=%h", {data_b_vld, data_b}, {1'b1, 16'hBEEF});
    end
  endtask

  initial begin
    rst     = 1'b1;
    din     = 16'h0;
    din_vld = 1'b0;
    channel = 2'd0;
    test_reset();
    test_single_words();
    test_backpressure();
    test_collision();
    test_invalid();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
